// File: rtl/ps2_pkg.sv
// ps2_pkg: shared types and constants for the PS/2 key event receiver
package ps2_pkg;

    typedef enum logic [1:0] {ST_IDLE, ST_DATA, ST_PARITY, ST_STOP} frame_st_e;

    localparam logic [7:0] PS2_EXT   = 8'hE0;
    localparam logic [7:0] PS2_BRK   = 8'hF0;
    localparam logic [7:0] PS2_PAUSE = 8'hE1;
    localparam int         PAUSE_LEN = 7;

    typedef struct packed {
        logic       ext;
        logic       brk;
        logic       rep;
        logic [7:0] code;
    } ps2_evt_t;

endpackage

// File: rtl/ps2_frame_rx.sv
// ps2_frame_rx: synchronises and filters the PS/2 pins and deserialises 11-bit frames
module ps2_frame_rx
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 200000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ps2_clk_i,
    input  logic       ps2_data_i,
    output logic       byte_vld_o,
    output logic [7:0] byte_o,
    output logic       frame_err_o
);
    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [1:0]    clk_s_q, dat_s_q;
    logic [FW-1:0] flt_cnt_q;
    logic          flt_q, flt_prev_q;
    frame_st_e     st_q;
    logic [2:0]    bit_q;
    logic [7:0]    sh_q;
    logic          par_ok_q;
    logic [TW-1:0] tmo_q;
    logic          strobe, din, tmo_hit;

    assign din     = dat_s_q[1];
    assign strobe  = flt_prev_q & ~flt_q;
    assign tmo_hit = (st_q != ST_IDLE) && (tmo_q == TW'(TIMEOUT_CYCLES - 1));

    // Filtered clock only follows the pin after FILTER_LEN consecutive differing samples
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_s_q    <= 2'b11;
            dat_s_q    <= 2'b11;
            flt_cnt_q  <= '0;
            flt_q      <= 1'b1;
            flt_prev_q <= 1'b1;
        end else begin
            clk_s_q    <= {clk_s_q[0], ps2_clk_i};
            dat_s_q    <= {dat_s_q[0], ps2_data_i};
            flt_prev_q <= flt_q;
            if (clk_s_q[1] == flt_q) begin
                flt_cnt_q <= '0;
            end else if (flt_cnt_q == FW'(FILTER_LEN - 1)) begin
                flt_q     <= clk_s_q[1];
                flt_cnt_q <= '0;
            end else begin
                flt_cnt_q <= flt_cnt_q + FW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q        <= ST_IDLE;
            bit_q       <= '0;
            sh_q        <= '0;
            par_ok_q    <= 1'b0;
            tmo_q       <= '0;
            byte_vld_o  <= 1'b0;
            byte_o      <= '0;
            frame_err_o <= 1'b0;
        end else begin
            byte_vld_o  <= 1'b0;
            frame_err_o <= 1'b0;
            tmo_q       <= (strobe || st_q == ST_IDLE) ? '0 : tmo_q + TW'(1);
            if (strobe) begin
                case (st_q)
                    ST_IDLE: begin
                        if (!din) st_q <= ST_DATA;
                        bit_q <= '0;
                    end
                    ST_DATA: begin
                        sh_q  <= {din, sh_q[7:1]};
                        bit_q <= bit_q + 3'd1;
                        if (bit_q == 3'd7) st_q <= ST_PARITY;
                    end
                    ST_PARITY: begin
                        par_ok_q <= ^{sh_q, din};
                        st_q     <= ST_STOP;
                    end
                    default: begin
                        st_q        <= ST_IDLE;
                        byte_o      <= sh_q;
                        byte_vld_o  <= din && par_ok_q;
                        frame_err_o <= !(din && par_ok_q);
                    end
                endcase
            end else if (tmo_hit) begin
                st_q        <= ST_IDLE;
                frame_err_o <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/ps2_key_event_rx.sv
// ps2_key_event_rx: PS/2 keyboard front end decoding prefixes into a ready/valid key event FIFO
module ps2_key_event_rx
    import ps2_pkg::*;
#(
    parameter int                  FILTER_LEN      = 8,
    parameter int                  TIMEOUT_CYCLES  = 200000,
    parameter int                  FIFO_DEPTH      = 8,
    parameter bit                  SUPPRESS_REPEAT = 1'b0,
    parameter int                  NTRACK          = 4,
    parameter logic [9*NTRACK-1:0] TRACK_CODES     = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ps2_clk,
    input  logic              ps2_data,
    output logic              evt_valid,
    input  logic              evt_ready,
    output logic [7:0]        evt_code,
    output logic              evt_ext,
    output logic              evt_break,
    output logic              evt_repeat,
    output logic [NTRACK-1:0] key_held,
    output logic              frame_err,
    output logic              overflow,
    input  logic              ovf_clr
);
    localparam int AW = $clog2(FIFO_DEPTH);

    logic       byte_vld;
    logic [7:0] rx_byte;

    ps2_frame_rx #(
        .FILTER_LEN    (FILTER_LEN),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_frame (
        .clk        (clk),
        .rst_n      (rst_n),
        .ps2_clk_i  (ps2_clk),
        .ps2_data_i (ps2_data),
        .byte_vld_o (byte_vld),
        .byte_o     (rx_byte),
        .frame_err_o(frame_err)
    );

    logic              ext_pend_q, brk_pend_q, last_vld_q, overflow_q;
    logic [2:0]        skip_q;
    logic [8:0]        last_make_q;
    logic [NTRACK-1:0] held_q, held_d;
    logic              is_evt, match, push, pop, full, wr_en;
    ps2_evt_t          evt, head;
    logic [AW:0]       wr_q, rd_q;
    ps2_evt_t          mem_q [FIFO_DEPTH];

    assign is_evt = byte_vld && skip_q == '0 && rx_byte != PS2_EXT
                    && rx_byte != PS2_BRK && rx_byte != PS2_PAUSE;
    assign match  = last_vld_q && last_make_q == {ext_pend_q, rx_byte};
    assign evt    = '{ext: ext_pend_q, brk: brk_pend_q, rep: !brk_pend_q && match, code: rx_byte};
    assign push   = is_evt && !(SUPPRESS_REPEAT && evt.rep);

    always_comb begin
        held_d = held_q;
        for (int i = 0; i < NTRACK; i++)
            if (is_evt && {ext_pend_q, rx_byte} == TRACK_CODES[9*i +: 9]) held_d[i] = !brk_pend_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ext_pend_q  <= 1'b0;
            brk_pend_q  <= 1'b0;
            skip_q      <= '0;
            last_make_q <= '0;
            last_vld_q  <= 1'b0;
            held_q      <= '0;
        end else if (byte_vld) begin
            if (skip_q != '0) begin
                skip_q <= skip_q - 3'd1;
            end else if (rx_byte == PS2_PAUSE) begin
                skip_q     <= 3'(PAUSE_LEN);
                ext_pend_q <= 1'b0;
                brk_pend_q <= 1'b0;
            end else if (rx_byte == PS2_EXT) begin
                ext_pend_q <= 1'b1;
            end else if (rx_byte == PS2_BRK) begin
                brk_pend_q <= 1'b1;
            end else begin
                ext_pend_q <= 1'b0;
                brk_pend_q <= 1'b0;
                held_q     <= held_d;
                if (!brk_pend_q) begin
                    last_make_q <= {ext_pend_q, rx_byte};
                    last_vld_q  <= 1'b1;
                end else if (match) begin
                    last_vld_q <= 1'b0;
                end
            end
        end
    end

    // Pointers carry one extra wrap bit so full and empty are distinguishable
    assign evt_valid = wr_q != rd_q;
    assign full      = (wr_q - rd_q) == (AW+1)'(FIFO_DEPTH);
    assign pop       = evt_valid && evt_ready;
    assign wr_en     = push && (!full || pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q       <= '0;
            rd_q       <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_q       <= wr_q + (AW+1)'(wr_en);
            rd_q       <= rd_q + (AW+1)'(pop);
            overflow_q <= (push && !wr_en) || (overflow_q && !ovf_clr);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_q[AW-1:0]] <= evt;
    end

    assign head       = mem_q[rd_q[AW-1:0]];
    assign evt_code   = head.code;
    assign evt_ext    = head.ext;
    assign evt_break  = head.brk;
    assign evt_repeat = head.rep;
    assign key_held   = held_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_ps2_key_event_rx.sv
// tb_ps2_key_event_rx: PS/2 device model driving two receivers, scoreboarded event checks
`timescale 1ns/100ps
module tb_ps2_key_event_rx;
    import ps2_pkg::*;

    localparam real HALF_CLK = 312.5;    // 1.6 MHz system clock: 40 cycles per 25 us bit
    localparam real HALF_BIT = 12500.0;
    localparam int  TMO      = 1000;
    localparam logic [35:0] TRACK = {9'h174, 9'h02B, 9'h01C, 9'h175};

    logic clk = 1'b0, rst_n = 1'b0, ps2_clk = 1'b1, ps2_data = 1'b1;
    logic evt_ready = 1'b0, ovf_clr = 1'b0, hit;
    logic evt_valid, evt_ext, evt_break, evt_repeat, frame_err, overflow;
    logic [7:0] evt_code;
    logic [3:0] key_held;
    logic evt_valid1, evt_ext1, evt_break1, evt_repeat1, frame_err1, overflow1;
    logic [7:0] evt_code1;
    logic [3:0] key_held1;

    int checks = 0, passed = 0, err_cnt = 0, e0;
    ps2_evt_t exp_q[$], exp1_q[$], got1_q[$];

    typedef struct {
        logic [7:0] b;
        logic       ev;
        ps2_evt_t   e;
        logic [3:0] held;
    } vec_t;
    vec_t tbl[$];

    always #(HALF_CLK) clk = ~clk;

    ps2_key_event_rx #(.FILTER_LEN(8), .TIMEOUT_CYCLES(TMO), .FIFO_DEPTH(8),
                       .SUPPRESS_REPEAT(1'b0), .NTRACK(4), .TRACK_CODES(TRACK)) dut (
        .clk(clk), .rst_n(rst_n), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_code(evt_code), .evt_ext(evt_ext),
        .evt_break(evt_break), .evt_repeat(evt_repeat), .key_held(key_held),
        .frame_err(frame_err), .overflow(overflow), .ovf_clr(ovf_clr)
    );

    ps2_key_event_rx #(.FILTER_LEN(8), .TIMEOUT_CYCLES(TMO), .FIFO_DEPTH(8),
                       .SUPPRESS_REPEAT(1'b1), .NTRACK(4), .TRACK_CODES(TRACK)) dut_sup (
        .clk(clk), .rst_n(rst_n), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .evt_valid(evt_valid1), .evt_ready(1'b1), .evt_code(evt_code1), .evt_ext(evt_ext1),
        .evt_break(evt_break1), .evt_repeat(evt_repeat1), .key_held(key_held1),
        .frame_err(frame_err1), .overflow(overflow1), .ovf_clr(ovf_clr)
    );

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    endtask

    function automatic logic [10:0] frame(input logic [7:0] b, input logic bad);
        return {1'b1, ~(^b) ^ bad, b, 1'b0};
    endfunction

    task automatic ps2_bits(input logic [10:0] f, input int n);
        for (int i = 0; i < n; i++) begin
            ps2_data = f[i];
            #(HALF_BIT) ps2_clk = 1'b0;
            #(HALF_BIT) ps2_clk = 1'b1;
        end
    endtask

    task automatic ps2_send(input logic [7:0] b);
        ps2_bits(frame(b, 1'b0), 11);
        ps2_data = 1'b1;
        #(4*HALF_BIT);
    endtask

    task automatic add(input logic [7:0] b, input logic ev, input logic ext, input logic brk,
                       input logic rep, input logic [3:0] held);
        vec_t v;
        v.b    = b;
        v.ev   = ev;
        v.e    = '{ext: ext, brk: brk, rep: rep, code: b};
        v.held = held;
        tbl.push_back(v);
    endtask

    task automatic expect_evt(input logic [7:0] code, input logic ext, input logic brk);
        exp_q.push_back('{ext: ext, brk: brk, rep: 1'b0, code: code});
    endtask

    task automatic drain_wait();
        for (int c = 0; c < 200 && exp_q.size() != 0; c++) @(posedge clk);
    endtask

    // Scoreboard: every accepted head is compared against the oldest expected event
    always @(negedge clk) begin
        if (frame_err) err_cnt++;
        if (evt_valid1) got1_q.push_back({evt_ext1, evt_break1, evt_repeat1, evt_code1});
        if (evt_valid && evt_ready) begin
            if (exp_q.size() == 0)
                chk("unexpected_evt", {21'd0, evt_ext, evt_break, evt_repeat, evt_code}, 32'hFFFF_FFFF);
            else
                chk("evt", {21'd0, evt_ext, evt_break, evt_repeat, evt_code}, 32'(exp_q.pop_front()));
        end
    end

    initial begin
        repeat (5) @(posedge clk);
        #1;
        chk("rst_evt_valid", evt_valid, 0);
        chk("rst_key_held", key_held, 0);
        chk("rst_frame_err", frame_err, 0);
        chk("rst_overflow", overflow, 0);
        rst_n     = 1'b1;
        evt_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1;

        add(8'h1C, 1, 0, 0, 0, 4'b0010);
        add(8'hF0, 0, 0, 0, 0, 4'b0010);
        add(8'h1C, 1, 0, 1, 0, 4'b0000);
        add(8'hE0, 0, 0, 0, 0, 4'b0000);
        add(8'h75, 1, 1, 0, 0, 4'b0001);
        add(8'hE0, 0, 0, 0, 0, 4'b0001);
        add(8'h75, 1, 1, 0, 1, 4'b0001);
        add(8'hE0, 0, 0, 0, 0, 4'b0001);
        add(8'hF0, 0, 0, 0, 0, 4'b0001);
        add(8'h75, 1, 1, 1, 0, 4'b0000);
        add(8'hE1, 0, 0, 0, 0, 4'b0000);
        add(8'h14, 0, 0, 0, 0, 4'b0000);
        add(8'h77, 0, 0, 0, 0, 4'b0000);
        add(8'hE1, 0, 0, 0, 0, 4'b0000);
        add(8'hF0, 0, 0, 0, 0, 4'b0000);
        add(8'h14, 0, 0, 0, 0, 4'b0000);
        add(8'hF0, 0, 0, 0, 0, 4'b0000);
        add(8'h77, 0, 0, 0, 0, 4'b0000);
        add(8'h1C, 1, 0, 0, 0, 4'b0010);
        add(8'hF0, 0, 0, 0, 0, 4'b0010);
        add(8'h1C, 1, 0, 1, 0, 4'b0000);

        for (int i = 0; i < tbl.size(); i++) begin
            if (tbl[i].ev) begin
                exp_q.push_back(tbl[i].e);
                if (!tbl[i].e.rep) exp1_q.push_back(tbl[i].e);
            end
            ps2_send(tbl[i].b);
            chk($sformatf("held_%0d", i), 32'(key_held), 32'(tbl[i].held));
        end
        chk("no_frame_err", err_cnt, 0);
        chk("table_drained", exp_q.size(), 0);
        chk("suppress_count", got1_q.size(), exp1_q.size());
        for (int i = 0; i < got1_q.size() && i < exp1_q.size(); i++)
            chk($sformatf("suppress_evt_%0d", i), 32'(got1_q[i]), 32'(exp1_q[i]));

        // Sub-filter glitches with data low would look like start bits if accepted
        e0       = err_cnt;
        ps2_data = 1'b0;
        for (int g = 1; g <= 6; g++) begin
            @(posedge clk); #1 ps2_clk = 1'b0;
            repeat (g) @(posedge clk);
            #1 ps2_clk = 1'b1;
            repeat (12) @(posedge clk);
        end
        ps2_data = 1'b1;
        expect_evt(8'h1C, 0, 0);
        ps2_send(8'h1C);
        chk("glitch_held", key_held, 4'b0010);
        chk("glitch_no_err", err_cnt - e0, 0);
        expect_evt(8'h1C, 0, 1);
        ps2_send(8'hF0);
        ps2_send(8'h1C);

        e0 = err_cnt;
        ps2_bits(frame(8'h1C, 1'b1), 11);
        ps2_data = 1'b1;
        #(4*HALF_BIT);
        chk("parity_err", err_cnt - e0, 1);
        chk("parity_no_evt", evt_valid, 0);
        chk("parity_held", key_held, 4'b0000);

        e0 = err_cnt;
        ps2_bits(frame(8'h1C, 1'b0), 5);
        ps2_data = 1'b1;
        repeat (TMO / 2) @(posedge clk);
        chk("no_early_timeout", err_cnt - e0, 0);
        repeat (TMO) @(posedge clk);
        chk("timeout_err", err_cnt - e0, 1);
        expect_evt(8'h1C, 0, 0);
        ps2_send(8'h1C);
        chk("after_timeout_held", key_held, 4'b0010);
        expect_evt(8'h1C, 0, 1);
        ps2_send(8'hF0);
        ps2_send(8'h1C);
        drain_wait();
        chk("t3_drained", exp_q.size(), 0);

        @(posedge clk); #1 evt_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (i < 8) expect_evt(8'(8'h15 + i), 0, 0);
            ps2_send(8'(8'h15 + i));
        end
        chk("overflow_set", overflow, 1);
        chk("head_valid", evt_valid, 1);
        chk("head_code", evt_code, 8'h15);
        @(posedge clk); #1 ovf_clr = 1'b1;
        @(posedge clk); #1 ovf_clr = 1'b0;
        chk("overflow_clr", overflow, 0);
        // Release the consumer in the very cycle the next push hits the full FIFO
        expect_evt(8'h22, 0, 0);
        hit = 1'b0;
        fork
            ps2_send(8'h22);
            begin
                for (int c = 0; c < 1000 && !hit; c++) begin
                    @(posedge clk);
                    #1 hit = dut.u_frame.byte_vld_o;
                end
                evt_ready = 1'b1;
                chk("push_at_full_seen", hit, 1);
            end
        join
        drain_wait();
        chk("full_pushpop_drained", exp_q.size(), 0);
        chk("full_pushpop_no_ovf", overflow, 0);

        @(posedge clk); #1 evt_ready = 1'b0;
        ps2_send(8'h1C);
        chk("t6_pending", evt_valid, 1);
        chk("t6_held_pre", key_held, 4'b0010);
        ps2_send(8'hE0);
        ps2_bits(frame(8'h2B, 1'b0), 4);
        @(posedge clk); #1 rst_n = 1'b0;
        ps2_data = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("t6_rst_evt_valid", evt_valid, 0);
        chk("t6_rst_key_held", key_held, 0);
        chk("t6_rst_frame_err", frame_err, 0);
        chk("t6_rst_overflow", overflow, 0);
        @(posedge clk); #1 rst_n = 1'b1;
        evt_ready = 1'b1;
        expect_evt(8'h2B, 0, 0);
        ps2_send(8'h2B);
        chk("t6_held_post", key_held, 4'b0100);
        drain_wait();
        chk("final_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
